elevator_request_latch: RTL and testbench
=========================================

// Module: elevator_request_latch
//
// PURPOSE
// Front-end stage feeding elevator_ctrl. It synchronises and debounces the raw cab
// buttons and hall up/down buttons, then latches each press as a pending request.
// Pending requests drive elevator_ctrl's buttons/ups/downs inputs and the button lamps.
// A request is cleared when the car opens its doors at that floor.
//
// PARAMETERS
// floor_numbers  10  number of floors; sets the width of every request vector (max 16)
// SYNC_STAGES    2   flip-flop synchroniser depth per raw input bit (>=2)
// DB_DEPTH       4   consecutive equal synchronised samples required to change debounced state (>=2)
//
// PORTS
// clock        in   1              system clock, rising edge
// reset        in   1              synchronous, active-high
// raw_buttons  in   floor_numbers  asynchronous cab buttons, 1 = pressed
// raw_ups      in   floor_numbers  asynchronous hall-up buttons
// raw_downs    in   floor_numbers  asynchronous hall-down buttons
// floor        in   4              current floor from elevator_ctrl
// open         in   1              door-open indication from elevator_ctrl
// buttons      out  floor_numbers  pending cab requests (registered)
// ups          out  floor_numbers  pending hall-up requests (registered)
// downs        out  floor_numbers  pending hall-down requests (registered)
// any_request  out  1              OR of all pending bits (registered)
//
// BEHAVIOUR
// - Reset, evaluated synchronously at the rising edge of clock:
//   - all synchroniser, history and debounced flops go to 0;
//   - buttons, ups, downs and any_request go to 0.
//   - Reset has priority over every other event. A reset mid-debounce discards the
//     partial history; a reset with doors open clears all pending requests.
// - Synchroniser: each raw bit passes through SYNC_STAGES flops.
// - Debounce, per bit:
//   - a DB_DEPTH-entry shift history of the synchronised value feeds a debounced state;
//   - the debounced state changes only when all DB_DEPTH history entries are equal and
//     differ from it;
//   - a glitch shorter than DB_DEPTH cycles never changes the debounced state.
// - Press event: debounced 0->1 transition. The pending bit sets on the same edge the
//   debounced state rises.
//   - Latency: a raw input rising and held is visible on the output after exactly
//     SYNC_STAGES+DB_DEPTH+1 clock edges (7 at defaults).
// - Release has no effect on pending bits; a held button yields a single set.
// - Illegal hall calls are masked and never set a pending bit:
//   - ups[floor_numbers-1] (no up call from the top floor);
//   - downs[0] (no down call from the ground floor).
// - Clear: on every edge where open==1 and floor<floor_numbers, bit [floor] of buttons,
//   ups and downs is cleared.
//   - floor>=floor_numbers clears nothing.
// - Simultaneous set and clear of the same bit: clear wins. A press at the floor being
//   served is considered served. Other bits set normally in that cycle.
// - A press event arriving after open deasserts sets the bit again (new request).
// - any_request is registered from next-state pending values, so it is coherent with
//   buttons/ups/downs in the same cycle.
// - No FSM beyond the per-bit debounce; all outputs are registered, with no
//   combinational input-to-output path.
//
// TESTING
// - Reset: assert reset 3 cycles with raw inputs all 1 -> all outputs 0 while reset is
//   high; after release, requests appear 7 edges later, except ups[9] and downs[0].
// - Latency: raw_buttons[5] 0->1 held -> buttons==10'h020 exactly on edge 7, any_request=1
//   on the same edge.
// - Glitch reject: raw_ups[2] high for 3 cycles then low -> ups stays 0; then high for
//   4+ cycles -> ups[2]=1.
// - Masking: raw_ups[9]=1 and raw_downs[0]=1 held 20 cycles -> ups[9]=0, downs[0]=0,
//   any_request=0.
// - Clear with collision:
//   - start with pending buttons[3], ups[3], downs[7];
//   - floor=3, open=1 for 5 cycles while a debounced press of raw_buttons[3] completes;
//   - required: buttons[3]=0 and ups[3]=0 one edge after open; downs[7] stays 1;
//     buttons[3] stays 0 while open=1.
// - Out-of-range floor: floor=12, open=1 with all pending bits set -> no bits cleared,
//   any_request stays 1.

Source files
------------

// File: rtl/elevator_request_latch_if.sv
// Button inputs, car position/door state and pending-request outputs of the request latch.
interface elevator_request_latch_if #(
    parameter int floor_numbers = 10
);
    logic [floor_numbers-1:0] raw_buttons;
    logic [floor_numbers-1:0] raw_ups;
    logic [floor_numbers-1:0] raw_downs;
    logic [3:0]               floor;
    logic                     open;
    logic [floor_numbers-1:0] buttons;
    logic [floor_numbers-1:0] ups;
    logic [floor_numbers-1:0] downs;
    logic                     any_request;

    modport master (
        output raw_buttons, raw_ups, raw_downs, floor, open,
        input  buttons, ups, downs, any_request
    );

    modport slave (
        input  raw_buttons, raw_ups, raw_downs, floor, open,
        output buttons, ups, downs, any_request
    );
endinterface

// File: rtl/elevator_request_latch.sv
// Synchronises, debounces and latches cab/hall button presses as pending requests.
// Latency SYNC_STAGES+DB_DEPTH+1 edges from raw press to output; no backpressure, level-sampled inputs.
module elevator_request_latch #(
    parameter int floor_numbers = 10,
    parameter int SYNC_STAGES   = 2,
    parameter int DB_DEPTH      = 4
) (
    input logic                     clock,
    input logic                     reset,
    elevator_request_latch_if.slave req
);
    localparam int N = floor_numbers;
    localparam int W = 3 * N;

    // Bit layout of every per-bit vector: {downs, ups, buttons}.
    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    logic [DB_DEPTH-1:0][W-1:0]    hist_q;
    logic [W-1:0]                  db_q;
    logic [W-1:0]                  pend_q;
    logic                          any_q;

    logic [W-1:0] raw_vec;
    logic [W-1:0] all_one;
    logic [W-1:0] all_zero;
    logic [W-1:0] rise;
    logic [W-1:0] legal;
    logic [N-1:0] clr;
    logic [W-1:0] pend_d;

    assign raw_vec = {req.raw_downs, req.raw_ups, req.raw_buttons};

    always_comb begin
        all_one  = '1;
        all_zero = '1;
        for (int k = 0; k < DB_DEPTH; k++) begin
            all_one  &= hist_q[k];
            all_zero &= ~hist_q[k];
        end
    end

    assign rise = all_one & ~db_q;

    // No up call from the top floor, no down call from the ground floor.
    always_comb begin
        legal        = '1;
        legal[2*N-1] = 1'b0;
        legal[2*N]   = 1'b0;
    end

    // Out-of-range floor values match no bit, so they clear nothing.
    always_comb begin
        clr = '0;
        for (int i = 0; i < N; i++) begin
            clr[i] = req.open && (req.floor == 4'(i));
        end
    end

    // Clear after set: a press at the floor being served is absorbed.
    assign pend_d = (pend_q | (rise & legal)) & ~{clr, clr, clr};

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= '0;
            db_q   <= '0;
            pend_q <= '0;
            any_q  <= 1'b0;
        end else begin
            sync_q[0] <= raw_vec;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            hist_q[0] <= sync_q[SYNC_STAGES-1];
            for (int k = 1; k < DB_DEPTH; k++) begin
                hist_q[k] <= hist_q[k-1];
            end
            db_q   <= (db_q | all_one) & ~all_zero;
            pend_q <= pend_d;
            any_q  <= |pend_d;
        end
    end

    assign req.buttons     = pend_q[N-1:0];
    assign req.ups         = pend_q[2*N-1:N];
    assign req.downs       = pend_q[W-1:2*N];
    assign req.any_request = any_q;
endmodule

// File: tb/tb_elevator_request_latch.sv
// Directed bench for elevator_request_latch; expectations queued at stimulus time, checked on the falling edge.
module tb_elevator_request_latch;
    localparam int N = 10;

    typedef struct {
        string        tag;
        logic [N-1:0] b;
        logic [N-1:0] u;
        logic [N-1:0] d;
        logic         a;
    } exp_t;

    logic clock;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    elevator_request_latch_if #(.floor_numbers(N)) bus ();

    elevator_request_latch #(
        .floor_numbers(N),
        .SYNC_STAGES  (2),
        .DB_DEPTH     (4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic expect_out(input string tag, input logic [N-1:0] b, input logic [N-1:0] u,
                              input logic [N-1:0] d, input logic a);
        exp_t e;
        e.tag = tag; e.b = b; e.u = u; e.d = d; e.a = a;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        logic [3*N:0] obs, want;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            e    = sb.pop_front();
            obs  = {bus.buttons, bus.ups, bus.downs, bus.any_request};
            want = {e.b, e.u, e.d, e.a};
            assert (obs === want) else begin
                errors++;
                $error("FAIL %s observed b=%h u=%h d=%h any=%b expected b=%h u=%h d=%h any=%b",
                       e.tag, bus.buttons, bus.ups, bus.downs, bus.any_request, e.b, e.u, e.d, e.a);
            end
        end
    endtask

    task automatic set_raw(input logic [N-1:0] b, input logic [N-1:0] u, input logic [N-1:0] d);
        bus.raw_buttons = b;
        bus.raw_ups     = u;
        bus.raw_downs   = d;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        tick(n);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        bus.floor = 4'd0;
        bus.open  = 1'b0;
        set_raw('1, '1, '1);

        // Reset held three edges with every raw input pressed.
        expect_out("reset_c1", '0, '0, '0, 1'b0);
        tick(1); check_out();
        tick(1);
        expect_out("reset_c3", '0, '0, '0, 1'b0);
        tick(1); check_out();
        reset = 1'b0;
        expect_out("post_reset_e6", '0, '0, '0, 1'b0);
        tick(6); check_out();
        expect_out("post_reset_e7", 10'h3FF, 10'h1FF, 10'h3FE, 1'b1);
        tick(1); check_out();

        set_raw('0, '0, '0);
        do_reset(2);

        // Press latency.
        set_raw(10'h020, '0, '0);
        expect_out("latency_e6", '0, '0, '0, 1'b0);
        tick(6); check_out();
        expect_out("latency_e7", 10'h020, '0, '0, 1'b1);
        tick(1); check_out();

        // Glitch of three cycles is rejected, four cycles is accepted.
        set_raw(10'h020, 10'h004, '0);
        tick(3);
        set_raw(10'h020, '0, '0);
        expect_out("glitch3", 10'h020, '0, '0, 1'b1);
        tick(12); check_out();
        set_raw(10'h020, 10'h004, '0);
        tick(4);
        set_raw(10'h020, '0, '0);
        expect_out("press4", 10'h020, 10'h004, '0, 1'b1);
        tick(4); check_out();
        set_raw('0, '0, '0);
        expect_out("release_noeffect", 10'h020, 10'h004, '0, 1'b1);
        tick(12); check_out();

        // Illegal hall calls masked.
        do_reset(2);
        set_raw('0, 10'h200, 10'h001);
        expect_out("mask", '0, '0, '0, 1'b0);
        tick(20); check_out();
        set_raw('0, '0, '0);
        tick(8);

        // Clear at floor 3 while a fresh cab press at floor 3 completes.
        set_raw(10'h008, 10'h008, 10'h080);
        expect_out("clr_setup", 10'h008, 10'h008, 10'h080, 1'b1);
        tick(7); check_out();
        set_raw('0, '0, '0);
        tick(8);
        set_raw(10'h008, '0, '0);
        tick(3);
        bus.floor = 4'd3;
        bus.open  = 1'b1;
        expect_out("clr_first_edge", '0, '0, 10'h080, 1'b1);
        tick(1); check_out();
        expect_out("clr_collision", '0, '0, 10'h080, 1'b1);
        tick(4); check_out();
        bus.open = 1'b0;
        expect_out("held_after_open", '0, '0, 10'h080, 1'b1);
        tick(5); check_out();
        set_raw('0, '0, '0);
        tick(8);
        set_raw(10'h008, '0, '0);
        expect_out("repress_after_open", 10'h008, '0, 10'h080, 1'b1);
        tick(7); check_out();

        // Out-of-range floor clears nothing; in-range floor 9 clears bit 9.
        set_raw('0, '0, '0);
        do_reset(2);
        set_raw('1, '1, '1);
        expect_out("all_set", 10'h3FF, 10'h1FF, 10'h3FE, 1'b1);
        tick(7); check_out();
        bus.floor = 4'd12;
        bus.open  = 1'b1;
        expect_out("floor12", 10'h3FF, 10'h1FF, 10'h3FE, 1'b1);
        tick(3); check_out();
        bus.floor = 4'd9;
        expect_out("floor9", 10'h1FF, 10'h1FF, 10'h1FE, 1'b1);
        tick(1); check_out();

        // Reset with doors open clears everything.
        reset = 1'b1;
        expect_out("reset_open", '0, '0, '0, 1'b0);
        tick(1); check_out();
        reset    = 1'b0;
        bus.open = 1'b0;

        if (sb.size() != 0) begin
            errors++;
            checks++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
